// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 decode stage: RV32I opcodes,
// immediate-type select codes and the decode buffer state encoding.
package msrv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] IMM_I_LD   = 3'b000;
  localparam logic [2:0] IMM_I      = 3'b001;
  localparam logic [2:0] IMM_S      = 3'b010;
  localparam logic [2:0] IMM_B      = 3'b011;
  localparam logic [2:0] IMM_U      = 3'b100;
  localparam logic [2:0] IMM_J      = 3'b101;
  localparam logic [2:0] IMM_CSR    = 3'b110;
  localparam logic [2:0] IMM_I_JALR = 3'b111;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

endpackage

// File: rtl/msrv32_opcode_classifier.sv
// Combinational classifier: maps the head instruction's opcode/funct3 to an
// immediate-type select and flags unsupported encodings.
module msrv32_opcode_classifier
  import msrv32_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [2:0] imm_type,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    imm_type = IMM_I;
    illegal  = 1'b0;
    case (opcode)
      OP_LOAD:           imm_type = IMM_I_LD;
      OP_IMM:            imm_type = IMM_I;
      OP_STORE:          imm_type = IMM_S;
      OP_BRANCH:         imm_type = IMM_B;
      OP_LUI, OP_AUIPC:  imm_type = IMM_U;
      OP_JAL:            imm_type = IMM_J;
      OP_JALR:           imm_type = IMM_I_JALR;
      OP_SYSTEM:         imm_type = (funct3 != 3'b000) ? IMM_CSR : IMM_I;
      OP_OP, OP_FENCE:   imm_type = IMM_I;
      // Covers both unknown opcodes and compressed encodings (instr[1:0] != 2'b11).
      default:           illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/msrv32_decode_ctrl.sv
// Decode-stage controller: two-entry skid buffer between fetch and execute,
// with flush, opcode classification and a saturating stall counter.
module msrv32_decode_ctrl
  import msrv32_pkg::*;
#(
  parameter int             XLEN        = 32,
  parameter int             STALL_CNT_W = 16,
  parameter logic [XLEN-1:0] PC_RESET   = '0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   flush_in,
  input  logic                   in_valid_in,
  output logic                   in_ready_out,
  input  logic [XLEN-1:0]        instr_in,
  input  logic [XLEN-1:0]        pc_in,
  output logic                   out_valid_out,
  input  logic                   out_ready_in,
  output logic [XLEN-1:0]        instr_out,
  output logic [XLEN-1:0]        pc_out,
  output logic [2:0]             imm_type_out,
  output logic [4:0]             rd_addr_out,
  output logic [4:0]             rs1_addr_out,
  output logic [4:0]             rs2_addr_out,
  output logic [2:0]             funct3_out,
  output logic                   illegal_out,
  output logic [STALL_CNT_W-1:0] stall_cnt_out
);

  state_t            state, next_state;
  logic [XLEN-1:0]   main_instr, main_pc;
  logic [XLEN-1:0]   skid_instr, skid_pc;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic              in_ready;
  logic              accept, consume;
  logic [2:0]        cls_imm_type;
  logic              cls_illegal;

  assign out_valid_out = (state != ST_EMPTY);
  assign accept        = in_valid_in && in_ready;
  assign consume       = out_valid_out && out_ready_in;

  always_comb begin
    next_state = state;
    if (flush_in) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) next_state = ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      next_state = ST_FULL;
          else if (consume && !accept) next_state = ST_EMPTY;
        end
        ST_FULL:  if (consume) next_state = ST_ONE;
        default:  next_state = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the slots are plain registers, so resetting them is cheap and gives known outputs while EMPTY.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_EMPTY;
      in_ready   <= 1'b1;
      main_instr <= INSTR_NOP;
      main_pc    <= PC_RESET;
      skid_instr <= INSTR_NOP;
      skid_pc    <= PC_RESET;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state    <= next_state;
      in_ready <= (next_state != ST_FULL);
      if (!flush_in) begin
        if (state == ST_FULL && consume) begin
          main_instr <= skid_instr;
          main_pc    <= skid_pc;
        end else if (accept && (state == ST_EMPTY || consume)) begin
          main_instr <= instr_in;
          main_pc    <= pc_in;
        end else if (accept) begin
          skid_instr <= instr_in;
          skid_pc    <= pc_in;
        end
      end
    end
  end

  // Counts cycles where execute holds off a valid head; flush does not clear it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt <= '0;
    end else if (out_valid_out && !out_ready_in && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  msrv32_opcode_classifier u_classifier (
    .opcode   (main_instr[6:0]),
    .funct3   (main_instr[14:12]),
    .imm_type (cls_imm_type),
    .illegal  (cls_illegal)
  );

  assign in_ready_out  = in_ready;
  assign instr_out     = main_instr;
  assign pc_out        = main_pc;
  assign rd_addr_out   = main_instr[11:7];
  assign rs1_addr_out  = main_instr[19:15];
  assign rs2_addr_out  = main_instr[24:20];
  assign funct3_out    = main_instr[14:12];
  assign imm_type_out  = out_valid_out ? cls_imm_type : IMM_I;
  assign illegal_out   = out_valid_out && cls_illegal;
  assign stall_cnt_out = stall_cnt;

endmodule

// File: tb/tb_msrv32_decode_ctrl.sv
// Directed self-checking bench for msrv32_decode_ctrl (stall counter sized to
// 4 bits so saturation is reachable quickly).
module tb_msrv32_decode_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        out_valid_out;
  logic        out_ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [2:0]  imm_type_out;
  logic [4:0]  rd_addr_out, rs1_addr_out, rs2_addr_out;
  logic [2:0]  funct3_out;
  logic        illegal_out;
  logic [3:0]  stall_cnt_out;

  int checks = 0;
  int errors = 0;

  msrv32_decode_ctrl #(
    .XLEN(32), .STALL_CNT_W(4), .PC_RESET(32'h0000_0000)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .instr_in(instr_in), .pc_in(pc_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .instr_out(instr_out), .pc_out(pc_out), .imm_type_out(imm_type_out),
    .rd_addr_out(rd_addr_out), .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
    .funct3_out(funct3_out), .illegal_out(illegal_out), .stall_cnt_out(stall_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid_in = 1'b1;
    instr_in    = instr;
    pc_in       = pc;
  endtask

  // Classification vectors: instruction, expected imm_type, expected illegal.
  logic [31:0] cls_instr [6] = '{32'h12345037, 32'h0000006F, 32'h30002573,
                                 32'h000080E7, 32'h0000007F, 32'h00000073};
  logic [2:0]  cls_imm   [6] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b001, 3'b001};
  logic        cls_ill   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_in = 1'b1; flush_in = 1'b0; in_valid_in = 1'b0;
    instr_in = '0; pc_in = '0; out_ready_in = 1'b0;
    step(); step();
    rst_in = 1'b0;
    check("rst_valid", out_valid_out, 0);
    check("rst_ready", in_ready_out, 1);
    check("rst_instr", instr_out, 32'h0000_0013);
    check("rst_pc", pc_out, 32'h0);
    check("rst_imm", imm_type_out, 3'b001);
    check("rst_illegal", illegal_out, 0);
    check("rst_stall", stall_cnt_out, 0);

    // Asynchronous reset in the middle of a stalled transfer.
    offer(32'h00500093, 32'h100);
    step();
    in_valid_in = 1'b0;
    step(); step();
    check("pre_rst_stall", stall_cnt_out, 2);
    check("pre_rst_valid", out_valid_out, 1);
    #3 rst_in = 1'b1;
    #1;
    check("async_rst_valid", out_valid_out, 0);
    check("async_rst_ready", in_ready_out, 1);
    check("async_rst_instr", instr_out, 32'h0000_0013);
    check("async_rst_stall", stall_cnt_out, 0);
    step();
    rst_in = 1'b0;

    // Streaming, one word per cycle.
    out_ready_in = 1'b1;
    offer(32'h00500093, 32'h200);
    step();
    check("str0_valid", out_valid_out, 1);
    check("str0_instr", instr_out, 32'h00500093);
    check("str0_pc", pc_out, 32'h200);
    check("str0_imm", imm_type_out, 3'b001);
    check("str0_rd", rd_addr_out, 5'd1);
    check("str0_ready", in_ready_out, 1);
    offer(32'h00112023, 32'h204);
    step();
    check("str1_instr", instr_out, 32'h00112023);
    check("str1_imm", imm_type_out, 3'b010);
    check("str1_rs1", rs1_addr_out, 5'd2);
    check("str1_rs2", rs2_addr_out, 5'd1);
    check("str1_f3", funct3_out, 3'b010);
    check("str1_ready", in_ready_out, 1);
    offer(32'hFE000EE3, 32'h208);
    step();
    check("str2_instr", instr_out, 32'hFE000EE3);
    check("str2_imm", imm_type_out, 3'b011);
    check("str2_ready", in_ready_out, 1);
    in_valid_in = 1'b0;
    step();
    check("str_drain_valid", out_valid_out, 0);
    check("str_stall", stall_cnt_out, 0);

    // Back-pressure: two accepted, third held by fetch.
    out_ready_in = 1'b0;
    offer(32'h00100113, 32'h300);
    step();
    check("bp_a_ready", in_ready_out, 1);
    offer(32'h00200193, 32'h304);
    step();
    check("bp_full_ready", in_ready_out, 0);
    check("bp_full_head", instr_out, 32'h00100113);
    check("bp_stall1", stall_cnt_out, 1);
    offer(32'h00300213, 32'h308);
    step(); step();
    check("bp_hold_head", instr_out, 32'h00100113);
    check("bp_hold_pc", pc_out, 32'h300);
    check("bp_hold_ready", in_ready_out, 0);
    check("bp_stall3", stall_cnt_out, 3);
    out_ready_in = 1'b1;
    step();
    check("bp_b_instr", instr_out, 32'h00200193);
    check("bp_b_pc", pc_out, 32'h304);
    check("bp_b_ready", in_ready_out, 1);
    step();
    check("bp_c_instr", instr_out, 32'h00300213);
    check("bp_c_valid", out_valid_out, 1);
    in_valid_in = 1'b0;
    step();
    check("bp_drain_valid", out_valid_out, 0);
    check("bp_stall_after", stall_cnt_out, 3);

    // Flush while FULL with a jal presented at the same edge.
    out_ready_in = 1'b0;
    offer(32'h00100113, 32'h400);
    step();
    offer(32'h00200193, 32'h404);
    step();
    check("fl_full_ready", in_ready_out, 0);
    offer(32'h0000006F, 32'h408);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    in_valid_in = 1'b0;
    check("fl_valid", out_valid_out, 0);
    check("fl_ready", in_ready_out, 1);
    check("fl_stall", stall_cnt_out, 5);
    check("fl_empty_imm", imm_type_out, 3'b001);
    out_ready_in = 1'b1;
    offer(32'h00400293, 32'h500);
    step();
    check("fl_next_instr", instr_out, 32'h00400293);
    check("fl_next_pc", pc_out, 32'h500);
    check("fl_next_valid", out_valid_out, 1);
    in_valid_in = 1'b0;
    step();
    check("fl_drain_valid", out_valid_out, 0);

    // Classification sweep.
    for (int i = 0; i < 6; i++) begin
      offer(cls_instr[i], 32'h600 + 32'(i * 4));
      step();
      check($sformatf("cls%0d_imm", i), imm_type_out, cls_imm[i]);
      check($sformatf("cls%0d_ill", i), illegal_out, cls_ill[i]);
    end
    in_valid_in = 1'b0;
    step();
    check("cls_empty_ill", illegal_out, 0);

    // Stall counter saturation at 4'hF.
    out_ready_in = 1'b0;
    offer(32'h00500093, 32'h700);
    step();
    in_valid_in = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("sat_14", stall_cnt_out, 4'hE);
    step();
    check("sat_15", stall_cnt_out, 4'hF);
    for (int i = 0; i < 10; i++) step();
    check("sat_hold", stall_cnt_out, 4'hF);
    check("sat_head_stable", instr_out, 32'h00500093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_decode_ctrl.md
Name: msrv32_decode_ctrl

Overview:
- Registered decode-stage controller between instruction fetch and execute.
- Accepts fetched instruction/PC words over a valid/ready handshake and buffers up to two of them (main slot plus skid slot), so that back-pressure never drops an instruction.
- Classifies each instruction by opcode and produces the 3-bit immediate-type select, register addresses and an illegal flag for downstream.
- Supports pipeline flush from branch/trap resolution and counts back-pressure stall cycles.

Parameters:
- XLEN, 32, instruction and PC width.
- STALL_CNT_W, 16, width of the saturating stall counter.
- PC_RESET, 32'h0000_0000, value driven on pc_out while empty after reset.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- flush_in  input  1  discard all buffered instructions this cycle.
- in_valid_in  input  1  fetch presents an instruction.
- in_ready_out  output  1  decode can accept an instruction.
- instr_in  input  XLEN  fetched instruction word.
- pc_in  input  XLEN  PC of instr_in.
- out_valid_out  output  1  decoded instruction available.
- out_ready_in  input  1  execute consumes the decoded instruction.
- instr_out  output  XLEN  head instruction word.
- pc_out  output  XLEN  head PC.
- imm_type_out  output  3  immediate-type select for the head.
- rd_addr_out / rs1_addr_out / rs2_addr_out  output  5 each  instr[11:7] / [19:15] / [24:20].
- funct3_out  output  3  instr[14:12].
- illegal_out  output  1  head opcode is unsupported.
- stall_cnt_out  output  STALL_CNT_W  saturating back-pressure cycle count.

Behaviour:
- Reset (asynchronous, active-high):
  - State returns to EMPTY.
  - out_valid_out=0 and in_ready_out=1.
  - instr_out=32'h0000_0013 (NOP), pc_out=PC_RESET.
  - imm_type_out=3'b001, illegal_out=0, stall_cnt_out=0.
- Handshake rules:
  - An input transfer occurs when in_valid_in && in_ready_out.
  - An output transfer occurs when out_valid_out && out_ready_in.
  - Data and control outputs stay stable while out_valid_out=1 and out_ready_in=0.
- in_ready_out is registered and equals (next_state != FULL).
- Latency: a word accepted at edge N appears on the outputs after edge N, with out_valid_out=1, when the buffer was EMPTY.
- State machine (EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE.
  - ONE:
    - accept only -> FULL (word goes to the skid slot).
    - consume only -> EMPTY.
    - accept and consume together -> ONE (main slot reloaded with the new word).
  - FULL: in_ready_out=0; consume -> ONE (skid slot moves to main).
  - Inputs offered while FULL are not accepted; fetch must hold them.
- Flush (flush_in=1):
  - Next state EMPTY, out_valid_out=0 and in_ready_out=1 next cycle.
  - Any simultaneous input word is discarded.
  - Flush has priority over every other event.
- Decode is combinational on the head slot, using opcode = instr[6:0]:
  - 0000011 LOAD -> 000.
  - 0010011 OP-IMM -> 001.
  - 0100011 STORE -> 010.
  - 1100011 BRANCH -> 011.
  - 0110111 LUI and 0010111 AUIPC -> 100.
  - 1101111 JAL -> 101.
  - 1110011 SYSTEM with funct3!=000 -> 110; SYSTEM with funct3=000 -> 001.
  - 1100111 JALR -> 111.
  - 0110011 OP and 0001111 MISC-MEM -> 001 (immediate unused).
  - Any other opcode, or instr[1:0]!=2'b11 -> illegal_out=1, imm_type_out=001.
- illegal_out and imm_type_out are qualified by out_valid_out. When EMPTY they hold their reset values.
- Stall counter:
  - Increments on each cycle with out_valid_out && !out_ready_in.
  - Saturates at all-ones.
  - Unaffected by flush; cleared only by reset.
- Reset asserted mid-operation empties both slots immediately, with no partial output transfer.

Decomposition:
- Shared package msrv32_pkg holds:
  - opcode localparams: OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_OP, OP_FENCE.
  - imm-type codes: IMM_I_LD=000, IMM_I=001, IMM_S=010, IMM_B=011, IMM_U=100, IMM_J=101, IMM_CSR=110, IMM_I_JALR=111.
  - the state encoding.
- One sub-module is natural: msrv32_opcode_classifier, combinational, taking the head instruction and producing imm_type and illegal.
- The skid buffer and state machine stay in the top module.

Test Plan:
- Reset: assert rst_in asynchronously mid-cycle -> immediately out_valid_out=0, in_ready_out=1, instr_out=32'h0000_0013, stall_cnt_out=0.
- Streaming: out_ready_in=1; feed 32'h00500093 (addi), 32'h00112023 (sw), 32'hFE000EE3 (beq) back-to-back -> one per cycle, 1-cycle latency, imm_type_out 001, 010, 011, in_ready_out stays 1.
- Back-pressure: out_ready_in=0; offer three words -> two accepted and in_ready_out=0 after the second; stall_cnt_out increments each held cycle. Release -> words emerge in order, with no loss or duplication.
- Flush while FULL, with in_valid_in=1 presenting 32'h0000006F (jal) -> next cycle out_valid_out=0 and in_ready_out=1, jal not accepted; next offered word emerges as the head.
- Classification sweep:
  - 32'h12345037 (LUI) -> 100.
  - 32'h0000006F (JAL) -> 101.
  - 32'h30002573 (csrrs) -> 110.
  - 32'h000080E7 (JALR) -> 111.
  - 32'h0000007F -> illegal_out=1.
- Stall counter saturation with STALL_CNT_W=4: hold back-pressure for 20 cycles -> stall_cnt_out stops at 4'hF.
